serial_magnitude_comparator: RTL and testbench

//  Multi-cycle unsigned magnitude comparator for WIDTH-bit operands. Reuses one
//  bit2_comparator slice, scanning 2-bit digits MSB-first, one digit per cycle.

---
 rtl/serial_magnitude_comparator_if.sv | 35 +++
 rtl/serial_magnitude_comparator.sv | 201 ++++++++++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_magnitude_comparator_if.sv
// Handshake bundle for serial_magnitude_comparator.
// Groups the operand-side (in_valid/in_ready/a/b) and result-side
// (out_valid/out_ready/a_gt_b/a_eq_b/a_lt_b/busy) signals into one interface.
//
// Modports:
//   master : producer/consumer view (drives in_valid, a, b, out_ready)
//   slave  : comparator view (drives in_ready, out_valid, flags, busy)
//
// WIDTH must match the WIDTH of the comparator that uses the slave modport.
interface serial_magnitude_comparator_if #(
   parameter int WIDTH = 8
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic             a_gt_b;
   logic             a_eq_b;
   logic             a_lt_b;
   logic             busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, a_gt_b, a_eq_b, a_lt_b, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, a_gt_b, a_eq_b, a_lt_b, busy
   );

endinterface

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
// Multi-cycle unsigned magnitude comparator. One 2-bit comparator slice is
// reused to scan the operands MSB-first, one 2-bit digit per clock.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : serial_magnitude_comparator_if.slave
//          in_valid/in_ready/a/b       operand handshake (accepted in IDLE)
//          out_valid/out_ready         result handshake (held in DONE)
//          a_gt_b/a_eq_b/a_lt_b        registered result flags
//          busy                        high whenever not IDLE
//
// Parameters:
//   WIDTH : operand width, even and >= 2 (ND = WIDTH/2 digits)
//
// Build option:
//   SERIAL_CMP_EARLY_EXIT_EN defined   -> stop at the first unequal digit
//                                         (latency 1..ND)
//   SERIAL_CMP_EARLY_EXIT_EN undefined -> always scan all ND digits
//                                         (fixed latency ND)
//   The flags are identical in both builds.

// 2-bit unsigned comparator slice.
module bit2_comparator (
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic       gt,
   output logic       eq,
   output logic       lt
);
   assign gt = (x > y);
   assign eq = (x == y);
   assign lt = (x < y);
endmodule

module serial_magnitude_comparator #(
   parameter int WIDTH = 8
) (
   input logic                          clk,
   input logic                          rst,
   serial_magnitude_comparator_if.slave bus
);

   localparam int ND = WIDTH / 2;
   localparam int CW = (ND > 1) ? $clog2(ND) : 1;

   // Reject odd or too-narrow operand widths at elaboration.
   if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("serial_magnitude_comparator: WIDTH must be even and >= 2");
   end

   typedef enum logic [1:0] {
      IDLE,
      CMP,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [CW-1:0]    cnt;
   logic             gt_q;
   logic             eq_q;
   logic             lt_q;
   logic             slice_gt;
   logic             slice_eq;
   logic             slice_lt;

`ifndef SERIAL_CMP_EARLY_EXIT_EN
   // Decision from the first unequal digit, kept while the scan runs on.
   logic             dec_found;
   logic             dec_gt;
`endif

   // The single shared slice always looks at the top digit of the shift regs.
   bit2_comparator u_slice (
      .x  (sh_a[WIDTH-1 -: 2]),
      .y  (sh_b[WIDTH-1 -: 2]),
      .gt (slice_gt),
      .eq (slice_eq),
      .lt (slice_lt)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. CMP ends on the last digit, or on the first unequal
   // digit when early exit is built in.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (bus.in_valid) state_next = CMP;
         end
         CMP: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
            if (!slice_eq || (cnt == '0)) state_next = DONE;
`else
            if (cnt == '0) state_next = DONE;
`endif
         end
         DONE: begin
            if (bus.out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: operand capture, digit shifting, and the result flags. Flags
   // are only ever set on the way into DONE and are cleared on the result
   // handshake, so they read zero whenever out_valid is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_a      <= '0;
         sh_b      <= '0;
         cnt       <= '0;
         gt_q      <= 1'b0;
         eq_q      <= 1'b0;
         lt_q      <= 1'b0;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
         dec_found <= 1'b0;
         dec_gt    <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sh_a      <= bus.a;
                  sh_b      <= bus.b;
                  cnt       <= CW'(ND - 1);
`ifndef SERIAL_CMP_EARLY_EXIT_EN
                  dec_found <= 1'b0;
                  dec_gt    <= 1'b0;
`endif
               end
            end
            CMP: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
               if (!slice_eq) begin
                  gt_q <= slice_gt;
                  lt_q <= slice_lt;
               end else if (cnt == '0) begin
                  eq_q <= 1'b1;
               end else begin
                  sh_a <= sh_a << 2;
                  sh_b <= sh_b << 2;
                  cnt  <= cnt - 1'b1;
               end
`else
               if (cnt == '0) begin
                  if (dec_found) begin
                     gt_q <= dec_gt;
                     lt_q <= !dec_gt;
                  end else begin
                     gt_q <= slice_gt;
                     eq_q <= slice_eq;
                     lt_q <= slice_lt;
                  end
               end else begin
                  sh_a <= sh_a << 2;
                  sh_b <= sh_b << 2;
                  cnt  <= cnt - 1'b1;
                  if (!dec_found && !slice_eq) begin
                     dec_found <= 1'b1;
                     dec_gt    <= slice_gt;
                  end
               end
`endif
            end
            DONE: begin
               if (bus.out_ready) begin
                  gt_q <= 1'b0;
                  eq_q <= 1'b0;
                  lt_q <= 1'b0;
               end
            end
            default: begin
               gt_q <= 1'b0;
               eq_q <= 1'b0;
               lt_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.a_gt_b    = gt_q;
   assign bus.a_eq_b    = eq_q;
   assign bus.a_lt_b    = lt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator
// Directed bench for serial_magnitude_comparator at WIDTH=8 (ND=4).
// Expected flags and latencies are hand-derived from the operand digits;
// latency expectations follow whichever build option is compiled in.
module tb_serial_magnitude_comparator;

   localparam int WIDTH = 8;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   // Flag encoding used for expectations: {gt, eq, lt}.
   localparam logic [2:0] F_GT   = 3'b100;
   localparam logic [2:0] F_EQ   = 3'b010;
   localparam logic [2:0] F_LT   = 3'b001;
   localparam logic [2:0] F_NONE = 3'b000;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   serial_magnitude_comparator_if #(.WIDTH(WIDTH)) bus ();

   serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [2:0] flags();
      return {bus.a_gt_b, bus.a_eq_b, bus.a_lt_b};
   endfunction

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Presents one operand pair for a single cycle; called at posedge+1 with
   // the DUT idle, returns at posedge+1 just after the accept edge.
   task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv);
      bus.a        = av;
      bus.b        = bv;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Counts edges after the accept edge until out_valid rises (bounded).
   task automatic waitResult(output int lat);
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.out_valid) break;
      end
   endtask

   // Full operation with out_ready=1: latency, flags, then the clear.
   task automatic runCompare(input string tag, input logic [7:0] av,
                             input logic [7:0] bv, input int exp_lat,
                             input logic [2:0] exp_flags);
      int lat;
      applyStimulus(av, bv);
      waitResult(lat);
      checkOutput({tag, "_latency"}, lat, exp_lat);
      checkOutput({tag, "_flags"}, {29'd0, flags()}, {29'd0, exp_flags});
      @(posedge clk);
      #1;
      checkOutput({tag, "_cleared_valid"}, {31'd0, bus.out_valid}, 32'd0);
      checkOutput({tag, "_cleared_flags"}, {29'd0, flags()}, {29'd0, F_NONE});
   endtask

   logic [7:0] qa [3];
   logic [7:0] qb [3];
   logic [2:0] qf [3];

   initial begin
      int lat;
      int sent;
      int rcv;
      logic take;

      vectors      = 0;
      miscompares  = 0;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      bus.out_ready = 1'b1;

      // Reset state.
      #1;
      checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("reset_flags", {29'd0, flags()}, {29'd0, F_NONE});
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
      checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
      @(posedge clk);
      #1;

      // Equal operands, unequal at digit 1 / 3 / 4, later digits contradicting.
      runCompare("eq_a5", 8'hA5, 8'hA5, 4, F_EQ);
      runCompare("gt_c0_80", 8'hC0, 8'h80, EARLY ? 1 : 4, F_GT);
      runCompare("lt_12_13", 8'h12, 8'h13, 4, F_LT);
      runCompare("gt_3c_34", 8'h3C, 8'h34, EARLY ? 3 : 4, F_GT);
      runCompare("lt_4f_80", 8'h4F, 8'h80, EARLY ? 1 : 4, F_LT);
      runCompare("eq_zero", 8'h00, 8'h00, 4, F_EQ);
      runCompare("gt_ff_00", 8'hFF, 8'h00, EARLY ? 1 : 4, F_GT);

      // Result held under back-pressure; new operands are refused in DONE.
      bus.out_ready = 1'b0;
      applyStimulus(8'h40, 8'h80);
      waitResult(lat);
      checkOutput("bp_latency", lat, EARLY ? 1 : 4);
      bus.a        = 8'hFF;
      bus.b        = 8'h00;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
         checkOutput("bp_flags", {29'd0, flags()}, {29'd0, F_LT});
         checkOutput("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("bp_no_launch_busy", {31'd0, bus.busy}, 32'd0);
      end

      // Reset at edge 2 of an operation aborts it at once.
      applyStimulus(8'h00, 8'h03);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("rst_cmp_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("rst_cmp_out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("rst_cmp_flags", {29'd0, flags()}, {29'd0, F_NONE});
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      runCompare("after_rst_gt", 8'h03, 8'h00, 4, F_GT);

      // Reset while a result is pending drops it asynchronously.
      bus.out_ready = 1'b0;
      applyStimulus(8'hC0, 8'h80);
      waitResult(lat);
      checkOutput("rst_done_flags_before", {29'd0, flags()}, {29'd0, F_GT});
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_done_out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("rst_done_flags", {29'd0, flags()}, {29'd0, F_NONE});
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Three back-to-back operand pairs with in_valid held high.
      qa[0] = 8'h5A; qb[0] = 8'h5A; qf[0] = F_EQ;
      qa[1] = 8'h01; qb[1] = 8'h10; qf[1] = F_LT;
      qa[2] = 8'hFF; qb[2] = 8'hFE; qf[2] = F_GT;
      sent = 0;
      rcv  = 0;
      bus.a        = qa[0];
      bus.b        = qb[0];
      bus.in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         take = bus.in_valid && bus.in_ready;
         @(posedge clk);
         #1;
         if (take) begin
            sent++;
            if (sent < 3) begin
               bus.a = qa[sent];
               bus.b = qb[sent];
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         if (bus.out_valid) begin
            if (rcv < 3) begin
               checkOutput($sformatf("queue_flags_%0d", rcv), {29'd0, flags()},
                           {29'd0, qf[rcv]});
            end
            rcv++;
         end
      end
      checkOutput("queue_sent", sent, 3);
      checkOutput("queue_received", rcv, 3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
